// File: rtl/wb_dma_addr_gen.sv
// DMA channel word-address / beat-count generator with carry-select address split,
// terminal-count detection, fixed-address mode, aligned wrap bursts and overflow flag.
module wb_dma_addr_gen #(
  parameter int unsigned AW    = 30,
  parameter int unsigned SPLIT = 16,
  parameter int unsigned CW    = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_ld,
  input  logic [AW-1:0] i_ld_adr,
  input  logic [CW-1:0] i_ld_cnt,
  input  logic          i_inc_en,
  input  logic [1:0]    i_wrap_sz,
  input  logic          i_adv,
  output logic [AW-1:0] o_adr,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf
);

  localparam int unsigned HW = AW - SPLIT;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  localparam logic [HW-1:0]    HW_ONE = HW'(1);
  localparam logic [SPLIT:0]   LO_ONE = (SPLIT + 1)'(1);
  localparam logic [CW-1:0]    CW_ONE = CW'(1);

  logic [SPLIT-1:0] r_lo;
  logic [HW-1:0]    r_hi;
  logic [HW-1:0]    r_hi_p1;
  logic [CW-1:0]    r_cnt;
  logic             r_inc;
  logic [1:0]       r_wrap;
  logic             r_state;
  logic             r_done;
  logic             r_ovf;

  logic [SPLIT:0]   w_lo_sum;
  logic [SPLIT-1:0] w_wrap_mask;
  logic [SPLIT-1:0] w_lo_wrap;
  logic             w_lo_carry;
  logic             w_hi_ones;
  logic             w_accept;
  logic [HW-1:0]    w_ld_hi;

  assign w_lo_sum   = {1'b0, r_lo} + LO_ONE;
  assign w_lo_carry = w_lo_sum[SPLIT];
  assign w_hi_ones  = &r_hi;
  assign w_accept   = i_adv && (r_state == ST_ACTIVE);
  assign w_ld_hi    = i_ld_adr[AW-1:SPLIT];

  always_comb begin
    w_wrap_mask = '0;
    case (r_wrap)
      2'd1:    w_wrap_mask = SPLIT'(4'h3);
      2'd2:    w_wrap_mask = SPLIT'(4'h7);
      2'd3:    w_wrap_mask = SPLIT'(4'hF);
      default: w_wrap_mask = '0;
    endcase
  end

  // Wrap mode only rewrites the low W bits; the increment is shared with linear mode.
  assign w_lo_wrap = (r_lo & ~w_wrap_mask) | (w_lo_sum[SPLIT-1:0] & w_wrap_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_hi_p1 <= HW_ONE;
      r_cnt   <= '0;
      r_inc   <= 1'b0;
      r_wrap  <= '0;
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_clr) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else if (i_ld) begin
        r_lo    <= i_ld_adr[SPLIT-1:0];
        r_hi    <= w_ld_hi;
        r_hi_p1 <= w_ld_hi + HW_ONE;
        r_cnt   <= i_ld_cnt;
        r_inc   <= i_inc_en;
        r_wrap  <= i_wrap_sz;
        r_ovf   <= 1'b0;
        if (i_ld_cnt == '0) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= ST_ACTIVE;
        end
      end else if (w_accept) begin
        r_cnt <= r_cnt - CW_ONE;
        if (r_cnt == CW_ONE) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        if (r_inc) begin
          if (r_wrap == 2'd0) begin
            r_lo <= w_lo_sum[SPLIT-1:0];
            // Carry-select: the high half swaps in the precomputed +1 value.
            if (w_lo_carry) begin
              r_hi    <= r_hi_p1;
              r_hi_p1 <= r_hi_p1 + HW_ONE;
              if (w_hi_ones) r_ovf <= 1'b1;
            end
          end else begin
            r_lo <= w_lo_wrap;
          end
        end
      end
    end
  end

  assign o_adr  = {r_hi, r_lo};
  assign o_cnt  = r_cnt;
  assign o_busy = r_state;
  assign o_done = r_done;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_wb_dma_addr_gen.sv
// Directed + randomized bench for wb_dma_addr_gen against a word-address arithmetic model.
module tb_wb_dma_addr_gen;

  localparam int unsigned AW = 30;
  localparam int unsigned CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          ld = 1'b0;
  logic [AW-1:0] ld_adr = '0;
  logic [CW-1:0] ld_cnt = '0;
  logic          inc_en = 1'b0;
  logic [1:0]    wrap_sz = '0;
  logic          adv = 1'b0;
  logic [AW-1:0] adr_o;
  logic [CW-1:0] cnt_o;
  logic          busy_o, done_o, ovf_o;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [AW-1:0] m_adr;
  logic [CW-1:0] m_cnt;
  logic          m_busy, m_done, m_ovf, m_inc;
  logic [1:0]    m_wrap;

  wb_dma_addr_gen #(.AW(30), .SPLIT(16), .CW(12)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_ld(ld), .i_ld_adr(ld_adr),
    .i_ld_cnt(ld_cnt), .i_inc_en(inc_en), .i_wrap_sz(wrap_sz), .i_adv(adv),
    .o_adr(adr_o), .o_cnt(cnt_o), .o_busy(busy_o), .o_done(done_o), .o_ovf(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_adr = '0; m_cnt = '0; m_busy = 0; m_done = 0; m_ovf = 0; m_inc = 0; m_wrap = '0;
  endtask

  // Behavioural view: a word address that steps by one, with wrap as modulo arithmetic.
  task automatic model_step();
    int unsigned sz;
    logic nd;
    nd = 0;
    if (clr) begin
      m_busy = 0; m_cnt = '0; m_ovf = 0;
    end else if (ld) begin
      m_adr = ld_adr; m_cnt = ld_cnt; m_inc = inc_en; m_wrap = wrap_sz; m_ovf = 0;
      m_busy = (ld_cnt != 0); nd = (ld_cnt == 0);
    end else if (adv && m_busy) begin
      if (m_cnt == 1) begin m_busy = 0; nd = 1; end
      m_cnt = m_cnt - 1'b1;
      if (m_inc) begin
        if (m_wrap == 0) begin
          if (m_adr == {AW{1'b1}}) m_ovf = 1;
          m_adr = m_adr + 1'b1;
        end else begin
          sz = 1 << (m_wrap + 1);
          m_adr = AW'((m_adr - (m_adr % sz)) + ((m_adr + 1) % sz));
        end
      end
    end
    m_done = nd;
  endtask

  task automatic check_all();
    check("adr", 32'(adr_o), 32'(m_adr));
    check("cnt", 32'(cnt_o), 32'(m_cnt));
    check("busy", 32'(busy_o), 32'(m_busy));
    check("done", 32'(done_o), 32'(m_done));
    check("ovf", 32'(ovf_o), 32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic setin(input logic c, input logic l, input logic [AW-1:0] a,
                       input logic [CW-1:0] n, input logic ie, input logic [1:0] w,
                       input logic v);
    clr = c; ld = l; ld_adr = a; ld_cnt = n; inc_en = ie; wrap_sz = w; adv = v;
  endtask

  initial begin
    logic [AW-1:0] exp_carry [4];
    logic [AW-1:0] exp_wrap [4];
    int unsigned done_seen;
    int unsigned busy_seen;
    exp_carry = '{30'h0FFFF, 30'h10000, 30'h10001, 30'h10002};
    exp_wrap  = '{30'h1007, 30'h1000, 30'h1001, 30'h1002};
    model_reset();

    // Reset state
    #12;
    check_all();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Linear carry across split
    setin(0, 1, 30'h0000_FFFE, 4, 1, 0, 0); tick();
    check("ld_adr_valid", 32'(adr_o), 32'h0000_FFFE);
    done_seen = 0;
    setin(0, 0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("carry_adr", 32'(adr_o), 32'(exp_carry[i]));
      check("carry_cnt", 32'(cnt_o), 32'(3 - i));
      done_seen += done_o;
    end
    check("carry_busy_fall", 32'(busy_o), 32'd0);
    setin(0, 0, '0, '0, 0, 0, 0); tick();
    check("carry_done_once", done_seen, 32'd1);

    // Overflow
    setin(0, 1, 30'h3FFF_FFFF, 2, 1, 0, 0); tick();
    setin(0, 0, '0, '0, 0, 0, 1); tick();
    check("ovf_adr0", 32'(adr_o), 32'h0);
    check("ovf_set", 32'(ovf_o), 32'd1);
    tick();
    check("ovf_adr1", 32'(adr_o), 32'h1);
    setin(0, 0, '0, '0, 0, 0, 0); tick();
    check("ovf_sticky", 32'(ovf_o), 32'd1);

    // Wrap 8
    setin(0, 1, 30'h0000_1006, 4, 1, 2, 0); tick();
    check("ld_clears_ovf", 32'(ovf_o), 32'd0);
    setin(0, 0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_adr", 32'(adr_o), 32'(exp_wrap[i]));
    end
    check("wrap_no_ovf", 32'(ovf_o), 32'd0);

    // Fixed mode, zero count, adv in IDLE
    setin(0, 1, 30'h123, 3, 0, 0, 0); tick();
    setin(0, 0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fixed_adr", 32'(adr_o), 32'h123);
    end
    check("fixed_done", 32'(done_o), 32'd1);
    setin(0, 1, 30'h456, 0, 1, 0, 0); tick();
    check("zero_done", 32'(done_o), 32'd1);
    check("zero_busy", 32'(busy_o), 32'd0);
    setin(0, 0, '0, '0, 0, 0, 1); tick();
    check("idle_adv_adr", 32'(adr_o), 32'h456);
    check("idle_adv_done", 32'(done_o), 32'd0);

    // Priority: ld beats adv; clr beats ld; back-to-back ld on done
    setin(0, 1, 30'h200, 5, 1, 0, 0); tick();
    setin(0, 0, '0, '0, 0, 0, 1); tick();
    setin(0, 1, 30'h300, 7, 1, 0, 1); tick();
    check("ld_wins_cnt", 32'(cnt_o), 32'd7);
    check("ld_wins_adr", 32'(adr_o), 32'h300);
    setin(1, 1, 30'h400, 9, 1, 0, 1); tick();
    check("clr_cnt", 32'(cnt_o), 32'd0);
    check("clr_busy", 32'(busy_o), 32'd0);
    check("clr_adr_held", 32'(adr_o), 32'h300);
    setin(0, 1, 30'h500, 1, 1, 0, 0); tick();
    setin(0, 0, '0, '0, 0, 0, 1); tick();
    setin(0, 1, 30'h600, 2, 1, 0, 1); tick();
    check("b2b_busy", 32'(busy_o), 32'd1);

    // Asynchronous reset mid-burst
    setin(0, 0, '0, '0, 0, 0, 1); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst_n = 1'b1;
    setin(0, 0, '0, '0, 0, 0, 0);
    @(posedge clk); #1;

    // Randomized traffic
    busy_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 2))
        0: a = AW'($urandom);
        1: a = AW'(30'h0000_FFF0 + $urandom_range(0, 15) + ($urandom_range(0, 3) << 16));
        default: a = AW'(30'h3FFF_FFF0 + $urandom_range(0, 15));
      endcase
      setin($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, a,
            CW'($urandom_range(0, 24)), $urandom_range(0, 4) != 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
      tick();
      busy_seen += busy_o;
    end
    check("rand_exercised", 32'(busy_seen > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
